// File: rtl/pe_bram_responder.sv
// rtl/pe_bram_responder.sv - Vector store and run sequencer behind the PE controller BRAM port.
// Optional host readback port is built when PE_BRAM_HOST_READBACK_EN is defined.
module pe_bram_responder #(
    parameter int VECTOR_SIZE    = 64,
    parameter int L_RAM_SIZE     = 6,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  host_wr_valid,
    output logic                  host_wr_ready,
    input  logic [L_RAM_SIZE:0]   host_wr_addr,
    input  logic [31:0]           host_wr_data,
    input  logic                  host_run,
`ifdef PE_BRAM_HOST_READBACK_EN
    input  logic                  host_rd_valid,
    input  logic [L_RAM_SIZE:0]   host_rd_addr,
    output logic [31:0]           host_rd_data,
    output logic                  host_rd_data_valid,
`endif
    output logic                  busy,
    output logic                  result_valid,
    output logic [31:0]           result_data,
    output logic                  err_timeout,
    output logic                  err_oob,
    output logic                  pe_start,
    input  logic                  pe_done,
    input  logic [31:0]           BRAM_ADDR,
    input  logic [31:0]           BRAM_WRDATA,
    input  logic [3:0]            BRAM_WE,
    output logic [31:0]           BRAM_RDDATA
);

    localparam int AW    = L_RAM_SIZE + 1;
    localparam int DEPTH = 2 * VECTOR_SIZE;
    localparam int CW    = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_RUN     = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    logic [31:0] mem_q [0:DEPTH-1];

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_timeout_q, err_timeout_d;
    logic            err_oob_q, err_oob_d;
    logic [31:0]     result_data_q, result_data_d;
    logic            result_valid_q, result_valid_d;
    logic            busy_q, busy_d;
    logic            pe_start_q, pe_start_d;
    logic            host_wr_ready_q, host_wr_ready_d;
    logic [31:0]     rddata_q, rddata_d;

    logic [AW-1:0]   pe_idx;
    logic            pe_oob;
    logic            pe_wr_active;
    logic            host_wr_acc;
    logic [31:0]     word0_next;
    logic [3:0]      mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [31:0]     mem_wdata;
    logic            unused_addr_bits;

    assign pe_idx           = BRAM_ADDR[AW+1:2];
    assign pe_oob           = |BRAM_ADDR[31:AW+2];
    assign unused_addr_bits = ^BRAM_ADDR[1:0];
    assign host_wr_acc      = host_wr_valid && host_wr_ready_q;
    assign pe_wr_active     = ((state_q == S_START) || (state_q == S_RUN)) && !pe_oob;

    // Host and PE never own the write port in the same state, so a simple priority mux suffices.
    always_comb begin
        mem_we    = 4'b0000;
        mem_waddr = pe_idx;
        mem_wdata = BRAM_WRDATA;
        if (host_wr_acc) begin
            mem_we    = 4'b1111;
            mem_waddr = host_wr_addr;
            mem_wdata = host_wr_data;
        end else if (pe_wr_active) begin
            mem_we    = BRAM_WE;
        end
    end

    always_ff @(posedge aclk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we[i]) begin
                mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    // Word 0 as it will look after this edge, so a write landing with pe_done is captured.
    always_comb begin
        word0_next = mem_q[0];
        for (int i = 0; i < 4; i++) begin
            if (pe_wr_active && (pe_idx == '0) && BRAM_WE[i]) begin
                word0_next[8*i +: 8] = BRAM_WRDATA[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_timeout_d = err_timeout_q;
        err_oob_d     = err_oob_q;
        result_data_d = result_data_q;

        case (state_q)
            S_IDLE: begin
                if (host_run) begin
                    state_d       = S_START;
                    cnt_d         = '0;
                    err_timeout_d = 1'b0;
                    err_oob_d     = 1'b0;
                end
            end
            S_START: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (pe_done) begin
                    state_d       = S_CAPTURE;
                    result_data_d = word0_next;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = S_IDLE;
                    err_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pe_oob) begin
            err_oob_d = 1'b1;
        end

        rddata_d        = pe_oob ? 32'd0 : mem_q[pe_idx];
        host_wr_ready_d = (state_d == S_IDLE);
        busy_d          = (state_d != S_IDLE);
        pe_start_d      = (state_d == S_START);
        result_valid_d  = (state_d == S_CAPTURE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            err_timeout_q   <= 1'b0;
            err_oob_q       <= 1'b0;
            result_data_q   <= 32'd0;
            result_valid_q  <= 1'b0;
            busy_q          <= 1'b0;
            pe_start_q      <= 1'b0;
            host_wr_ready_q <= 1'b0;
            rddata_q        <= 32'd0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            err_timeout_q   <= err_timeout_d;
            err_oob_q       <= err_oob_d;
            result_data_q   <= result_data_d;
            result_valid_q  <= result_valid_d;
            busy_q          <= busy_d;
            pe_start_q      <= pe_start_d;
            host_wr_ready_q <= host_wr_ready_d;
            rddata_q        <= rddata_d;
        end
    end

    assign host_wr_ready = host_wr_ready_q;
    assign busy          = busy_q;
    assign result_valid  = result_valid_q;
    assign result_data   = result_data_q;
    assign err_timeout   = err_timeout_q;
    assign err_oob       = err_oob_q;
    assign pe_start      = pe_start_q;
    assign BRAM_RDDATA   = rddata_q;

`ifdef PE_BRAM_HOST_READBACK_EN
    logic [31:0] host_rd_data_q, host_rd_data_d;
    logic        host_rd_data_valid_q, host_rd_data_valid_d;

    always_comb begin
        host_rd_data_valid_d = host_rd_valid && (state_q == S_IDLE);
        host_rd_data_d       = host_rd_data_valid_d ? mem_q[host_rd_addr] : host_rd_data_q;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            host_rd_data_q       <= 32'd0;
            host_rd_data_valid_q <= 1'b0;
        end else begin
            host_rd_data_q       <= host_rd_data_d;
            host_rd_data_valid_q <= host_rd_data_valid_d;
        end
    end

    assign host_rd_data       = host_rd_data_q;
    assign host_rd_data_valid = host_rd_data_valid_q;
`endif

endmodule

// File: tb/tb_pe_bram_responder.sv
// tb/tb_pe_bram_responder.sv - Scoreboard bench for pe_bram_responder.
module tb_pe_bram_responder;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        host_wr_valid = 1'b0;
    logic        host_wr_ready;
    logic [6:0]  host_wr_addr = '0;
    logic [31:0] host_wr_data = '0;
    logic        host_run = 1'b0;
    logic        busy;
    logic        result_valid;
    logic [31:0] result_data;
    logic        err_timeout;
    logic        err_oob;
    logic        pe_start;
    logic        pe_done = 1'b0;
    logic [31:0] BRAM_ADDR = '0;
    logic [31:0] BRAM_WRDATA = '0;
    logic [3:0]  BRAM_WE = '0;
    logic [31:0] BRAM_RDDATA;
`ifdef PE_BRAM_HOST_READBACK_EN
    logic        host_rd_valid = 1'b0;
    logic [6:0]  host_rd_addr = '0;
    logic [31:0] host_rd_data;
    logic        host_rd_data_valid;
`endif

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    logic [31:0] rd_q[$];
    logic [31:0] res_q[$];
    logic pe_rd_en = 1'b0;
    logic rd_vld_d = 1'b0;

    pe_bram_responder #(.VECTOR_SIZE(64), .L_RAM_SIZE(6), .TIMEOUT_CYCLES(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
        .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data), .host_run(host_run),
`ifdef PE_BRAM_HOST_READBACK_EN
        .host_rd_valid(host_rd_valid), .host_rd_addr(host_rd_addr),
        .host_rd_data(host_rd_data), .host_rd_data_valid(host_rd_data_valid),
`endif
        .busy(busy), .result_valid(result_valid), .result_data(result_data),
        .err_timeout(err_timeout), .err_oob(err_oob), .pe_start(pe_start), .pe_done(pe_done),
        .BRAM_ADDR(BRAM_ADDR), .BRAM_WRDATA(BRAM_WRDATA), .BRAM_WE(BRAM_WE),
        .BRAM_RDDATA(BRAM_RDDATA)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic host_write(input logic [6:0] addr, input logic [31:0] data);
        host_wr_valid = 1'b1;
        host_wr_addr  = addr;
        host_wr_data  = data;
        tick();
        host_wr_valid = 1'b0;
    endtask

    task automatic pe_read(input logic [31:0] addr, input logic [31:0] exp);
        BRAM_ADDR = addr;
        rd_q.push_back(exp);
        pe_rd_en = 1'b1;
        tick();
        pe_rd_en = 1'b0;
    endtask

    task automatic pe_write(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] data);
        BRAM_ADDR   = addr;
        BRAM_WE     = we;
        BRAM_WRDATA = data;
        tick();
        BRAM_WE = 4'h0;
    endtask

    always @(posedge aclk) rd_vld_d <= pe_rd_en;

    // Monitor: read data one cycle after a PE read, result on every result_valid pulse.
    always @(negedge aclk) begin
        if (pe_start) start_cnt++;
        if (rd_vld_d) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL bram_rddata: read strobe with empty expectation queue");
            end else begin
                check("bram_rddata", BRAM_RDDATA, rd_q.pop_front());
            end
        end
        if (result_valid) begin
            if (res_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result_valid: got result 0x%08h expected no pulse", result_data);
            end else begin
                check("result_data", result_data, res_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_pe_start", 32'(pe_start), 0);
        check("rst_result_valid", 32'(result_valid), 0);
        check("rst_result_data", result_data, 0);
        check("rst_err_timeout", 32'(err_timeout), 0);
        check("rst_err_oob", 32'(err_oob), 0);
        check("rst_bram_rddata", BRAM_RDDATA, 0);
        check("rst_host_wr_ready", 32'(host_wr_ready), 0);
        aresetn = 1'b1;
        check("reset_cycle_ready", 32'(host_wr_ready), 0);
        tick();
        check("idle_ready", 32'(host_wr_ready), 1);

        for (int i = 0; i < 128; i++) host_write(7'(i), 32'(i + 1));

        // Run A: reads, blocked host traffic, result capture
        host_run = 1'b1;
        tick();
        host_run = 1'b0;
        check("pe_start_pulse", 32'(pe_start), 1);
        check("busy_start", 32'(busy), 1);
        check("ready_start", 32'(host_wr_ready), 0);
        tick();
        check("pe_start_single", 32'(pe_start), 0);
        pe_read(32'h000, 1);
        pe_read(32'h004, 2);
        pe_read(32'h1FC, 128);
        host_wr_valid = 1'b1;
        host_wr_addr  = 7'd3;
        host_wr_data  = 32'hFFFF_FFFF;
        host_run      = 1'b1;
        check("ready_run", 32'(host_wr_ready), 0);
        tick();
        host_wr_valid = 1'b0;
        host_run      = 1'b0;
        pe_read(32'h00C, 4);
        pe_write(32'h000, 4'hF, 32'hDEAD_BEEF);
        repeat (4) tick();
        res_q.push_back(32'hDEAD_BEEF);
        pe_done = 1'b1;
        tick();
        pe_done = 1'b0;
        check("result_valid_pulse", 32'(result_valid), 1);
        check("busy_capture", 32'(busy), 1);
        tick();
        check("result_valid_drop", 32'(result_valid), 0);
        check("busy_drop", 32'(busy), 0);
        check("ready_after_capture", 32'(host_wr_ready), 1);
        check("start_count_run_a", 32'(start_cnt), 1);

        pe_write(32'h014, 4'hF, 32'h0);
        pe_read(32'h014, 6);

        // Run B: byte enables, read-during-write, same-cycle write with pe_done
        host_run = 1'b1;
        tick();
        host_run = 1'b0;
        tick();
        pe_write(32'h020, 4'hF, 32'h1122_3344);
        pe_write(32'h020, 4'b0101, 32'hAABB_CCDD);
        pe_read(32'h020, 32'h11BB_33DD);
        BRAM_WE     = 4'hF;
        BRAM_WRDATA = 32'h0000_0099;
        pe_read(32'h024, 10);
        BRAM_WE = 4'h0;
        pe_read(32'h024, 32'h0000_0099);
        BRAM_ADDR   = 32'h0;
        BRAM_WE     = 4'hF;
        BRAM_WRDATA = 32'h1234_5678;
        res_q.push_back(32'h1234_5678);
        pe_done = 1'b1;
        tick();
        pe_done = 1'b0;
        BRAM_WE = 4'h0;
        tick();

        // Timeout run: 16 RUN cycles without pe_done
        host_run = 1'b1;
        tick();
        host_run = 1'b0;
        tick();
        repeat (15) tick();
        check("err_timeout_before", 32'(err_timeout), 0);
        check("busy_before_timeout", 32'(busy), 1);
        tick();
        check("err_timeout_set", 32'(err_timeout), 1);
        check("busy_after_timeout", 32'(busy), 0);
        check("ready_after_timeout", 32'(host_wr_ready), 1);
        tick();

        host_run = 1'b1;
        tick();
        host_run = 1'b0;
        check("err_timeout_cleared", 32'(err_timeout), 0);
        tick();
        pe_read(32'h0000_1000, 0);
        check("err_oob_set", 32'(err_oob), 1);
        BRAM_ADDR = 32'h0;
        tick();
        #2;
        aresetn = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_err_oob", 32'(err_oob), 0);
        check("async_rst_pe_start", 32'(pe_start), 0);
        check("async_rst_rddata", BRAM_RDDATA, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        repeat (3) tick();
        check("busy_after_reset", 32'(busy), 0);
        check("start_count_total", 32'(start_cnt), 4);
        pe_read(32'h014, 6);
        tick();
        tick();
        check("rd_queue_drained", 32'(rd_q.size()), 0);
        check("res_queue_drained", 32'(res_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_bram_responder.md
Name: pe_bram_responder

Overview:
- Memory-side responder for the PE controller's BRAM master port. It owns the vector store that the PE controller reads operands from and writes its result into.
- Host side: a valid/ready word loader fills the store. A run pulse launches the PE controller. The scalar result is captured after the controller signals completion.
- Sits between the host/testbench and the PE controller; replaces the external BRAM in simulation and in standalone builds.

Parameters:
VECTOR_SIZE, 64, elements per operand vector
L_RAM_SIZE, 6, log2(VECTOR_SIZE); store depth = 2*VECTOR_SIZE words, word index width AW = L_RAM_SIZE+1
TIMEOUT_CYCLES, 4096, max cycles in RUN before abort

Ports:
aclk  in  1  single clock; all logic on rising edge
aresetn  in  1  asynchronous, active-low reset
host_wr_valid  in  1  host word write request
host_wr_ready  out  1  high only in IDLE
host_wr_addr  in  AW  word index
host_wr_data  in  32  write data
host_run  in  1  launch request, sampled in IDLE only
busy  out  1  high in START/RUN/CAPTURE
result_valid  out  1  one-cycle pulse, result_data updated
result_data  out  32  captured word 0, held until next capture
err_timeout  out  1  sticky; cleared by next accepted host_run
err_oob  out  1  sticky; cleared by next accepted host_run
pe_start  out  1  one-cycle start to PE controller
pe_done  in  1  done pulse from PE controller
BRAM_ADDR  in  32  byte address from PE controller
BRAM_WRDATA  in  32  PE write data
BRAM_WE  in  4  PE byte write enables
BRAM_RDDATA  out  32  read data to PE controller

Behaviour:
- Reset (async assert, sync release): state IDLE; host_wr_ready=0 for the reset cycle, then 1; busy=0, pe_start=0, result_valid=0, result_data=0, err_*=0, BRAM_RDDATA=0, timeout counter=0. Memory contents not reset.
- Word index = BRAM_ADDR[AW+1:2]. BRAM_ADDR[1:0] ignored. BRAM_ADDR[31:AW+2] nonzero = out of range.
- PE read: BRAM_RDDATA registered, 1-cycle latency, every cycle regardless of state. Out-of-range read returns 0 and sets err_oob.
- PE write: only in START/RUN. Per-byte: BRAM_WE[i] writes byte i. Out-of-range write is dropped and sets err_oob. PE writes in IDLE/CAPTURE are ignored; no error.
- Host write: accepted when host_wr_valid && host_wr_ready. Full 32-bit word. Single shared write port; ownership set by state, so no arbitration conflict.
- Read-during-write, same word: BRAM_RDDATA returns old data.
- FSM:
  - IDLE: host_run -> START. A host write in the same cycle is still accepted. It clears err_* and the timeout counter.
  - START: pe_start=1 for exactly this cycle -> RUN.
  - RUN: counter increments each cycle. pe_done -> CAPTURE. If the counter reaches TIMEOUT_CYCLES-1 without pe_done: set err_timeout -> IDLE, no result_valid.
  - CAPTURE: result_data <= mem[0], including a PE write to word 0 committed in the same cycle as pe_done. result_valid=1 for this cycle -> IDLE.
- host_run outside IDLE is ignored. pe_done outside RUN is ignored.
- Reset mid-run: immediate return to IDLE with reset values. No pe_start is reissued.

Optional Feature:
- Macro: PE_BRAM_HOST_READBACK_EN.
- Defined: adds ports host_rd_valid (in 1), host_rd_addr (in AW), host_rd_data (out 32), host_rd_data_valid (out 1).
  - Read accepted in IDLE only; data and valid registered 1 cycle later.
  - A request outside IDLE is dropped; host_rd_data_valid stays 0.
  - host_rd_data resets to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Load words 0..127 with value index+1, pulse host_run; PE model reads 0x000,0x004,0x1FC -> BRAM_RDDATA 1,2,128 one cycle after each address; pe_start high exactly 1 cycle after run.
- PE model writes BRAM_WE=4'hF, data 0xDEADBEEF at address 0, pe_done 5 cycles later -> result_data=0xDEADBEEF with result_valid pulse 1 cycle after pe_done; busy falls the same cycle.
- BRAM_WE=4'b0101, data 0xAABBCCDD over word 0x11223344 -> word reads 0x11BB33DD.
- Host write attempted during RUN -> host_wr_ready=0, memory unchanged; host_run during RUN ignored, no second pe_start.
- TIMEOUT_CYCLES=16, no pe_done -> err_timeout=1 after 16 RUN cycles, state IDLE, no result_valid; next host_run clears err_timeout.
- BRAM_ADDR=0x00001000 read -> BRAM_RDDATA=0, err_oob=1; async aresetn pulse mid-RUN -> busy=0, err_oob=0 immediately, memory word 5 retains its loaded value.
